// File: rtl/photon_core.sv
// photon_core -- PHOTON P256 permutation engine (PHOTON-224/32/32 internal permutation).
//
// The 256-bit state is eight 32-bit words. Word k is row k of an 8x8 matrix of
// 4-bit cells, and cell 0 is the most significant nibble. Software loads the
// words, issues HASH, waits for ready, then reads the permuted words back.
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high
//   opcode    in   2   00 NOP, 01 READ, 10 WRITE, 11 HASH (only acted on while idle)
//   addr      in   3   state word index
//   data_in   in  32   write data
//   data_out  out 32   registered read data, holds until next READ or reset
//   ready     out  1   1 = idle / result valid, 0 = permutation running
//
// Build option
//   PHOTON_UNROLL2_EN  when defined, two rounds are chained per cycle (6-cycle run).
//                      When undefined, one round per cycle (12-cycle run).
//
// FSM states
//   state | meaning
//   IDLE  | accepts READ / WRITE / HASH
//   RUN   | applying rounds rnd (and rnd+1 when unrolled); commands ignored

module photon_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  opcode,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [3:0]       rnd, rnd_nx;
  logic [7:0][31:0] st, st_nx;
  logic [7:0][31:0] step;
  logic [31:0]      dout_nx;
  logic             last_rnd;

  function automatic logic [3:0] rc_of(input logic [3:0] t);
    case (t)
      4'd0:    rc_of = 4'h1;
      4'd1:    rc_of = 4'h3;
      4'd2:    rc_of = 4'h7;
      4'd3:    rc_of = 4'hE;
      4'd4:    rc_of = 4'hD;
      4'd5:    rc_of = 4'hB;
      4'd6:    rc_of = 4'h6;
      4'd7:    rc_of = 4'hC;
      4'd8:    rc_of = 4'h9;
      4'd9:    rc_of = 4'h2;
      4'd10:   rc_of = 4'h5;
      4'd11:   rc_of = 4'hA;
      default: rc_of = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] ic_of(input logic [2:0] r);
    case (r)
      3'd0:    ic_of = 4'h0;
      3'd1:    ic_of = 4'h1;
      3'd2:    ic_of = 4'h3;
      3'd3:    ic_of = 4'h7;
      3'd4:    ic_of = 4'hF;
      3'd5:    ic_of = 4'hE;
      3'd6:    ic_of = 4'hC;
      default: ic_of = 4'h8;
    endcase
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] a);
    case (a)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  // Multiply by x modulo x^4+x+1.
  function automatic logic [3:0] xtime(input logic [3:0] a);
    xtime = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  // GF(2^4) product with a constant k; synthesises to a small XOR network.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] k);
    logic [3:0] p;
    logic [3:0] m;
    p = 4'h0;
    m = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ m;
      m = xtime(m);
    end
    gmul = p;
  endfunction

  function automatic logic [7:0][31:0] perm_round(input logic [7:0][31:0] s,
                                                   input logic [3:0]       t);
    logic [3:0]       x   [8][8];
    logic [3:0]       y   [8][8];
    logic [3:0]       col [8];
    logic [3:0]       v;
    logic [7:0][31:0] o;
    // AddConstants only touches column 0, folded in ahead of the S-box.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        x[r][c] = sbox(s[r][31-4*c -: 4] ^
                       ((c == 0) ? (rc_of(t) ^ ic_of(3'(r))) : 4'h0));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        y[r][c] = x[r][(c + r) % 8];
    // Serial MixColumns: eight shift-and-append steps, fully unrolled.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 8; i++) col[i] = y[i][c];
      for (int it = 0; it < 8; it++) begin
        v = gmul(col[0], 4'd2) ^ gmul(col[1], 4'd4) ^ gmul(col[2], 4'd2) ^
            gmul(col[3], 4'd11) ^ gmul(col[4], 4'd2) ^ gmul(col[5], 4'd8) ^
            gmul(col[6], 4'd5) ^ gmul(col[7], 4'd6);
        for (int i = 0; i < 7; i++) col[i] = col[i+1];
        col[7] = v;
      end
      for (int i = 0; i < 8; i++) y[i][c] = col[i];
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[r][31-4*c -: 4] = y[r][c];
    return o;
  endfunction

`ifdef PHOTON_UNROLL2_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  assign step     = perm_round(perm_round(st, rnd), rnd + 4'd1);
  assign last_rnd = (rnd == 4'd10);
`else
  localparam logic [3:0] RND_STEP = 4'd1;
  assign step     = perm_round(st, rnd);
  assign last_rnd = (rnd == 4'd11);
`endif

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rnd      <= 4'd0;
      st       <= '0;
      data_out <= 32'h0;
    end else begin
      state    <= state_nx;
      rnd      <= rnd_nx;
      st       <= st_nx;
      data_out <= dout_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rnd_nx   = rnd;
    st_nx    = st;
    dout_nx  = data_out;
    case (state)
      IDLE: begin
        case (opcode)
          2'b01: dout_nx = st[addr];
          2'b10: st_nx[addr] = data_in;
          2'b11: begin
            state_nx = RUN;
            rnd_nx   = 4'd0;
          end
          default: ;
        endcase
      end
      RUN: begin
        st_nx = step;
        if (last_rnd) begin
          state_nx = IDLE;
          rnd_nx   = 4'd0;
        end else begin
          rnd_nx = rnd + RND_STEP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_photon_core.sv
// tb_photon_core -- directed bench for photon_core with a cycle-level reference
// model. The model keeps the state as a flat 256-bit vector, counts busy cycles
// and applies the whole permutation when the run completes; the permutation is
// computed on integer cell arrays with carry-less multiply + polynomial reduction
// and a queue-based serial MixColumns.

module tb_photon_core;

  typedef logic [255:0] st_t;

`ifdef PHOTON_UNROLL2_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 12;
`endif

  localparam int RC [12] = '{1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10};
  localparam int IC [8]  = '{0, 1, 3, 7, 15, 14, 12, 8};
  localparam int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  localparam int MK [8]  = '{2, 4, 2, 11, 2, 8, 5, 6};

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  opcode;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  st_t         m_st;
  logic [31:0] m_dout;
  int          m_cnt;

  photon_core dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  function automatic int gm(int a, int b);
    int p = 0;
    for (int i = 0; i < 4; i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int bit_i = 6; bit_i >= 4; bit_i--)
      if (((p >> bit_i) & 1) != 0) p = p ^ ('h13 << (bit_i - 4));
    return p;
  endfunction

  function automatic logic [31:0] wd(st_t s, int k);
    return s[255-32*k -: 32];
  endfunction

  function automatic st_t p256(st_t s);
    int x [8][8];
    int row [8];
    int q [$];
    int v;
    st_t o;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        x[r][c] = int'(s[255-32*r-4*c -: 4]);
    for (int t = 0; t < 12; t++) begin
      for (int r = 0; r < 8; r++) x[r][0] = x[r][0] ^ RC[t] ^ IC[r];
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) x[r][c] = SB[x[r][c]];
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) row[c] = x[r][(c + r) % 8];
        for (int c = 0; c < 8; c++) x[r][c] = row[c];
      end
      for (int c = 0; c < 8; c++) begin
        q = {};
        for (int r = 0; r < 8; r++) q.push_back(x[r][c]);
        for (int n = 0; n < 8; n++) begin
          v = 0;
          for (int i = 0; i < 8; i++) v = v ^ gm(MK[i], q[i]);
          void'(q.pop_front());
          q.push_back(v);
        end
        for (int r = 0; r < 8; r++) x[r][c] = q[r];
      end
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[255-32*r-4*c -: 4] = 4'(x[r][c]);
    return o;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: same sampling edge as the DUT.
  always @(posedge clk) begin
    if (reset) begin
      m_st   <= '0;
      m_dout <= 32'h0;
      m_cnt  <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_st <= p256(m_st);
    end else begin
      case (opcode)
        2'b01: m_dout <= wd(m_st, int'(addr));
        2'b10: m_st[255-32*addr -: 32] <= data_in;
        2'b11: m_cnt <= LAT;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", {31'h0, ready}, {31'h0, m_cnt == 0});
      check("cyc_data_out", data_out, m_dout);
    end
  end

  task automatic cmd(logic [1:0] op, logic [2:0] a, logic [31:0] d);
    opcode  = op;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    opcode  = 2'b00;
  endtask

  task automatic start_hash();
    cmd(2'b11, 3'd0, 32'h0);
    check("hash_ready_fall", {31'h0, ready}, 32'h0);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load(st_t s);
    for (int k = 0; k < 8; k++) cmd(2'b10, 3'(k), wd(s, k));
  endtask

  task automatic read_all(string name, st_t s);
    for (int k = 0; k < 8; k++) begin
      cmd(2'b01, 3'(k), 32'h0);
      check(name, data_out, wd(s, k));
    end
  endtask

  initial begin
    st_t iv, exp1, exp2;
    int cyc;
    iv   = '0;
    iv[31:0] = 32'h00382020;
    exp1 = p256(iv);
    exp2 = p256(exp1);

    // Pin the model's field arithmetic with hand-computed products.
    check("gf_2x8", 32'(gm(2, 8)), 32'h3);
    check("gf_11x3", 32'(gm(11, 3)), 32'hE);
    check("gf_6x7", 32'(gm(6, 7)), 32'h1);

    reset = 1'b1; opcode = 2'b00; addr = 3'd0; data_in = 32'h0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_ready", {31'h0, ready}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      cmd(2'b01, 3'(k), 32'h0);
      check("rst_read", data_out, 32'h0);
    end

    // Write / read-back
    for (int k = 0; k < 8; k++) cmd(2'b10, 3'(k), 32'h11111111 * (k + 1));
    for (int k = 0; k < 8; k++) begin
      cmd(2'b01, 3'(k), 32'h0);
      check("wr_readback", data_out, 32'h11111111 * (k + 1));
    end

    // IV permutation and latency
    load(iv);
    start_hash();
    wait_ready(cyc);
    check("hash_latency", 32'(cyc), 32'(LAT));
    read_all("iv_result", exp1);

    // Commands during a run are ignored
    load(iv);
    start_hash();
    cmd(2'b10, 3'd3, 32'hFFFFFFFF);
    cmd(2'b01, 3'd3, 32'h0);
    check("busy_read_hold", data_out, wd(exp1, 7));
    wait_ready(cyc);
    check("busy_latency", 32'(cyc), 32'(LAT - 2));
    read_all("busy_result", exp1);

    // Back-to-back HASH
    load(iv);
    start_hash();
    wait_ready(cyc);
    check("b2b_latency1", 32'(cyc), 32'(LAT));
    start_hash();
    wait_ready(cyc);
    check("b2b_latency2", 32'(cyc), 32'(LAT));
    read_all("b2b_result", exp2);

    // Reset mid-run
    load(iv);
    start_hash();
    repeat (4) cmd(2'b00, 3'd0, 32'h0);
    check("pre_rst_busy", {31'h0, ready}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_ready", {31'h0, ready}, 32'h1);
    check("midrst_dout", data_out, 32'h0);
    read_all("midrst_read", '0);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
